// File: rtl/vga_timing_core.sv
// ============================================================================
// Module   : vga_timing_core
// Brief    : Parametrised raster timing generator (FP->SYNC->BP->ACTIVE order)
//            with clock enable, registered X/Y/DE and delayed sync/strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12,
    parameter int DE_DELAY = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x_px,
    output logic [CW-1:0] y_px,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_end
);

    localparam int c_BLANK_H = H_FP + H_SYNC + H_BP;
    localparam int c_H_TOTAL = c_BLANK_H + H_ACTIVE;
    localparam int c_BLANK_V = V_FP + V_SYNC + V_BP;
    localparam int c_V_TOTAL = c_BLANK_V + V_ACTIVE;

    localparam logic [CW-1:0] c_H_MAX    = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_MAX    = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_BLANK  = CW'(c_BLANK_H);
    localparam logic [CW-1:0] c_V_BLANK  = CW'(c_BLANK_V);
    localparam logic [CW-1:0] c_HS_BEG   = CW'(H_FP);
    localparam logic [CW-1:0] c_HS_END   = CW'(H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_BEG   = CW'(V_FP);
    localparam logic [CW-1:0] c_VS_END   = CW'(V_FP + V_SYNC);
    localparam logic          c_HS_ACT   = (HS_POL != 0);
    localparam logic          c_VS_ACT   = (VS_POL != 0);
    // Bundle order: {hsync, vsync, de, line_start, frame_start, frame_end}
    localparam logic [5:0]    c_IDLE     = {~c_HS_ACT, ~c_VS_ACT, 4'b0000};

    generate
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
            $error("vga_timing_core: porch and sync widths must be at least 1");
        end
        if (CW < 1 || CW > 30 || c_H_TOTAL > (2 ** CW) || c_V_TOTAL > (2 ** CW)) begin : g_chk_cw
            $error("vga_timing_core: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
        if (DE_DELAY < 0 || DE_DELAY > 7) begin : g_chk_delay
            $error("vga_timing_core: DE_DELAY must be in 0..7");
        end
    endgenerate

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          w_de;
    logic [5:0]    w_dec;
    logic [5:0]    r_stg0;
    logic [5:0]    w_out;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (en) begin
            if (r_hc == c_H_MAX) begin
                r_hc <= '0;
                r_vc <= (r_vc == c_V_MAX) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign w_de  = (r_hc >= c_H_BLANK) && (r_vc >= c_V_BLANK);
    assign w_dec = {
        ((r_hc >= c_HS_BEG) && (r_hc < c_HS_END)) ? c_HS_ACT : ~c_HS_ACT,
        ((r_vc >= c_VS_BEG) && (r_vc < c_VS_END)) ? c_VS_ACT : ~c_VS_ACT,
        w_de,
        (r_hc == '0),
        (r_hc == '0) && (r_vc == '0),
        (r_hc == c_H_MAX) && (r_vc == c_V_MAX)
    };

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg0 <= c_IDLE;
            r_x    <= '0;
            r_y    <= '0;
        end else if (en) begin
            r_stg0 <= w_dec;
            r_x    <= w_de ? (r_hc - c_H_BLANK) : '0;
            r_y    <= w_de ? (r_vc - c_V_BLANK) : '0;
        end
    end

    // Only sync/DE/strobes are delayed; coordinates keep single-cycle latency.
    generate
        if (DE_DELAY == 0) begin : g_no_delay
            assign w_out = r_stg0;
        end else begin : g_delay
            logic [5:0] r_pipe [DE_DELAY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DE_DELAY; i++) begin
                        r_pipe[i] <= c_IDLE;
                    end
                end else if (en) begin
                    r_pipe[0] <= r_stg0;
                    for (int i = 1; i < DE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_out = r_pipe[DE_DELAY-1];
        end
    endgenerate

    assign {hsync, vsync, de, line_start, frame_start, frame_end} = w_out;
    assign x_px = r_x;
    assign y_px = r_y;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_core.sv
// ============================================================================
// Module   : tb_vga_timing_core
// Brief    : Directed self-checking bench: default 640x480 timing instance and
//            a small inverted-polarity instance with DE_DELAY=3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, en_a, hs_a, vs_a, de_a, ls_a, fs_a, fe_a;
    logic [11:0] x_a, y_a;
    logic        rst_b_n, en_b, hs_b, vs_b, de_b, ls_b, fs_b, fe_b;
    logic [4:0]  x_b, y_b;

    vga_timing_core u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .en(en_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x_px(x_a), .y_px(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_end(fe_a)
    );

    // 15 x 8 raster: BLANK_H=7, BLANK_V=4
    vga_timing_core #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CW(5), .DE_DELAY(3)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .en(en_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x_px(x_b), .y_px(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_end(fe_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int t0, t_de, n, bad;

        rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
        repeat (3) tick();

        chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);
        chk("a_rst_de", de_a, 0);
        chk("a_rst_xy", {x_a, y_a}, 0);
        chk("a_rst_strobes", {ls_a, fs_a, fe_a}, 0);
        chk("b_rst_syncs", {hs_b, vs_b}, 0);
        chk("b_rst_de_strobes", {de_b, ls_b, fs_b, fe_b}, 0);

        // ---------------- default instance ----------------
        rst_a_n = 1'b1;
        tick();
        t0 = cyc;
        chk("a_first_fs", fs_a, 1);
        chk("a_first_ls", ls_a, 1);
        chk("a_first_hs", hs_a, 1);

        n = 0; while (hs_a !== 1'b0 && n < 2000) begin tick(); n++; end
        chk("a_hs_fall_time", cyc - t0, 16);
        t_de = cyc;
        n = 0; while (hs_a !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("a_hs_width", cyc - t_de, 96);
        n = 0; while (ls_a !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("a_line_period", cyc - t0, 800);

        n = 0; while (vs_a !== 1'b0 && n < 20000) begin tick(); n++; end
        chk("a_vs_fall_time", cyc - t0, 8000);
        t_de = cyc;
        n = 0; while (vs_a !== 1'b1 && n < 20000) begin tick(); n++; end
        chk("a_vs_width", cyc - t_de, 1600);

        n = 0; while (de_a !== 1'b1 && n < 40000) begin tick(); n++; end
        chk("a_de_first_time", cyc - t0, 36160);
        chk("a_de_first_xy", {x_a, y_a}, 0);
        t_de = cyc;
        n = 0; bad = 0;
        while (de_a === 1'b1 && n < 1000) begin
            if (x_a !== n[11:0]) bad++;
            n++;
            tick();
        end
        chk("a_de_width", n, 640);
        chk("a_x_ramp_errors", bad, 0);
        chk("a_x_blank", x_a, 0);

        n = 0; while (de_a !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("a_de_line_period", cyc - t_de, 800);
        chk("a_y_line1", y_a, 1);
        t_de = cyc;

        n = 0; while (x_a !== 12'd100 && n < 2000) begin tick(); n++; end
        chk("a_reach_x100", x_a, 100);
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (x_a !== 12'd100) bad++;
        end
        chk("a_stall_hold", bad, 0);
        en_a = 1'b1;
        tick();
        chk("a_stall_resume", x_a, 101);
        n = 0; while (de_a !== 1'b0 && n < 2000) begin tick(); n++; end
        n = 0; while (de_a !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("a_stall_line_period", cyc - t_de, 805);
        chk("a_y_line2", y_a, 2);

        // ---------------- small inverted / delayed instance ----------------
        rst_b_n = 1'b1;
        t0 = cyc;
        tick();
        chk("b_fs_edge1", fs_b, 0);
        chk("b_x_edge1", x_b, 0);
        repeat (3) tick();
        chk("b_fs_edge4", fs_b, 1);
        chk("b_ls_edge4", ls_b, 1);

        n = 0; while (hs_b !== 1'b1 && n < 500) begin tick(); n++; end
        chk("b_hs_rise_time", cyc - t0, 6);
        n = 0; while (hs_b !== 1'b0 && n < 500) begin tick(); n++; end
        chk("b_hs_fall_time", cyc - t0, 9);
        n = 0; while (vs_b !== 1'b1 && n < 500) begin tick(); n++; end
        chk("b_vs_rise_time", cyc - t0, 19);
        n = 0; while (de_b !== 1'b1 && n < 500) begin tick(); n++; end
        chk("b_de_rise_time", cyc - t0, 71);
        chk("b_de_lag_x", x_b, 3);
        chk("b_de_lag_y", y_b, 0);
        n = 0; while (fe_b !== 1'b1 && n < 500) begin tick(); n++; end
        chk("b_fe_time", cyc - t0, 123);
        chk("b_fs_not_with_fe", fs_b, 0);
        tick();
        chk("b_fs_after_fe", fs_b, 1);
        chk("b_fe_one_cycle", fe_b, 0);

        n = 0; while (!(x_b === 5'd5 && y_b === 5'd2) && n < 500) begin tick(); n++; end
        chk("b_pre_reset_de", de_b, 1);
        #2 rst_b_n = 1'b0;
        #1;
        chk("b_async_de", de_b, 0);
        chk("b_async_xy", {x_b, y_b}, 0);
        chk("b_async_syncs", {hs_b, vs_b}, 0);
        tick();
        rst_b_n = 1'b1;
        t0 = cyc;
        tick();
        chk("b_rel_x", x_b, 0);
        chk("b_rel_de", de_b, 0);
        tick(); tick();
        chk("b_rel_fs_edge3", fs_b, 0);
        tick();
        chk("b_rel_fs_edge4", fs_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
